mux16_rr_sched: RTL and testbench
=================================

Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares the 16-input, 3-bit bus multiplexer between 16 requesters. It arbitrates among the requests, drives the 4-bit select and a one-hot grant, and moves a burst of up to MAX_BURST beats from the granted input through the mux. The output side uses a valid/ready handshake, so a downstream consumer can stall the transfer. It sits directly in front of the mux16x1_bus datapath and owns its select input.

Parameters:
DW, 3, data width of each input bus and of dout.
MAX_BURST, 4, maximum beats per grant; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  16  req[i] high = requester i has data on its bus; must stay high for as long as it has beats to send
din  input  16*DW  packed input buses; requester i occupies din[i*DW +: DW]
dout_ready  input  1  downstream accepts the current beat
sel  output  4  mux select, equal to the granted index; registered
grant  output  16  one-hot grant, all zero when no burst is active; registered
dout  output  DW  muxed data, din[sel*DW +: DW] while dout_valid is high, else 0
dout_valid  output  1  beat available, equal to busy & req[sel]
busy  output  1  a burst is active (state BURST)

Behaviour:
- Reset (async, on rst high):
  - state=IDLE, ptr=0, cnt=0.
  - Outputs: sel=0, grant=0, busy=0, dout_valid=0, dout=0.
  - Asserting rst mid-burst aborts the burst immediately; beats not yet handshaken are dropped.
- State machine has two states, IDLE and BURST.
- IDLE:
  - If req is nonzero, select the winner: the first index k with req[k]=1, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - On the next edge: sel=k, grant=1<<k, cnt=0, state=BURST.
  - If req is zero, stay in IDLE.
  - Latency from req assertion to grant is 1 clock.
- BURST:
  - dout and dout_valid are combinational from din, req and the registered sel.
  - A beat transfers on an edge where dout_valid & dout_ready are both high; cnt increments on each transfer.
  - The burst ends at an edge where either:
    - a beat transfers with cnt==MAX_BURST-1, or
    - req[sel]==0 (no transfer on that edge).
  - On burst end: grant=0, ptr=(sel+1) mod 16 (15 wraps to 0), state=IDLE. sel holds its last value.
  - There is always exactly one IDLE cycle between consecutive bursts.
- Stall: dout_ready low holds sel, grant, dout and cnt unchanged. There is no timeout.
- req changes on non-granted lines during BURST are ignored until the next IDLE cycle.
- Fairness: a requester that stays asserted is granted within 15 bursts.
- cnt is wide enough to hold MAX_BURST-1 (4 bits). MAX_BURST=1 gives single-beat grants.

Test Plan:
- Reset mid-burst: req[3]=1, ready=1, assert rst after 2 beats -> grant=0, busy=0, dout_valid=0 on the same cycle. After release with req[3] still high, grant=0x0008 again after 1 clock.
- Single requester, max burst: req=0x0020, din5=3'b101, ready=1 -> grant=0x0020 and sel=5 one cycle later. Exactly 4 beats of dout=5. Then 1 IDLE cycle, then a new 4-beat burst.
- Round-robin rotation and wrap: req=0x8001 held, ready=1 -> grant order 0,15,0,15. ptr wraps from 15 to 0 correctly.
- Early termination: req[7] granted, drops after 2 beats -> burst ends with cnt=2, no third transfer, busy falls on that edge, ptr=8.
- Backpressure: req[2]=1, dout_ready low for 5 cycles mid-burst -> dout, sel and cnt stable during the stall. Total transferred beats is still 4.
- All requesting: req=0xFFFF, ptr=0, MAX_BURST=1 -> grants 0,1,...,15,0 in order, with one IDLE cycle between each.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin burst scheduler for a 16-input DW-bit bus mux.
// Grants one requester at a time, moving up to MAX_BURST beats over valid/ready.
module mux16_rr_sched #(
  parameter int DW        = 3,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     req,
  input  logic [16*DW-1:0] din,
  input  logic            dout_ready,
  output logic [3:0]      sel,
  output logic [15:0]     grant,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            busy
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  sel_n;
  logic [15:0] grant_n;
  logic [3:0]  win;
  logic        found;
  logic        xfer;

  // First requester at or after ptr, wrapping mod 16.
  always_comb begin : pick
    logic [3:0] idx;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign busy       = (state == BURST);
  assign dout_valid = busy & req[sel];
  assign dout       = dout_valid ? din[int'(sel)*DW +: DW] : '0;
  assign xfer       = dout_valid & dout_ready;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    sel_n   = sel;
    grant_n = grant;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BURST;
          sel_n   = win;
          grant_n = 16'(1) << win;
          cnt_n   = '0;
        end
      end
      BURST: begin
        if (!req[sel] || (xfer && cnt == LAST)) begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = sel + 4'd1;
        end
        if (xfer) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      sel   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      grant <= grant_n;
    end
  end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: table vectors, directed corner sequences,
// and random traffic against a burst-level reference model.
module tb_mux16_rr_sched;

  localparam int DW = 3;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [15:0]    req = '0;
  logic [16*DW-1:0] din = '0;
  logic           dout_ready = 1'b0;

  logic [3:0]     sel, sel1;
  logic [15:0]    grant, grant1;
  logic [DW-1:0]  dout, dout1;
  logic           dout_valid, dout_valid1;
  logic           busy, busy1;

  mux16_rr_sched #(.DW(DW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .dout_ready(dout_ready), .sel(sel), .grant(grant),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  mux16_rr_sched #(.DW(DW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .dout_ready(dout_ready), .sel(sel1), .grant(grant1),
    .dout(dout1), .dout_valid(dout_valid1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  // model: burst-level view (who holds the bus, beats moved so far)
  bit m_busy;
  int m_sel, m_ptr, m_beats;

  // snapshots taken at the falling edge
  logic [3:0]  s_sel;
  logic [15:0] s_grant, s1_grant;
  logic        s_busy, s_valid, s_ready, s1_busy;
  logic [2:0]  s_dout;

  function automatic void m_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
  endfunction

  task automatic m_step();
    if (rst) begin
      m_reset();
    end else if (!m_busy) begin
      for (int i = 0; i < 16; i++) begin
        int k;
        k = (m_ptr + i) % 16;
        if (req[k]) begin
          m_busy = 1; m_sel = k; m_beats = 0;
          break;
        end
      end
    end else if (!req[m_sel]) begin
      m_busy = 0; m_ptr = (m_sel + 1) % 16;
    end else if (dout_ready) begin
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0; m_ptr = (m_sel + 1) % 16;
      end
    end
  endtask

  function automatic logic [24:0] m_exp();
    logic       v;
    logic [2:0] d;
    logic [15:0] g;
    v = m_busy && req[m_sel];
    d = v ? din[m_sel*DW +: DW] : 3'd0;
    g = m_busy ? (16'd1 << m_sel) : 16'd0;
    return {4'(m_sel), g, 1'(m_busy), v, d};
  endfunction

  function automatic logic [24:0] dut_out();
    return {sel, grant, busy, dout_valid, dout};
  endfunction

  task automatic chk(input string name,
                     input logic [24:0] got,
                     input logic [24:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [15:0] q,
                       input logic [47:0] d, input logic rdy);
    rst = r; req = q; din = d; dout_ready = rdy;
    if (r) m_reset();
  endtask

  task automatic snap();
    s_sel = sel; s_grant = grant; s_busy = busy;
    s_valid = dout_valid; s_dout = dout; s_ready = dout_ready;
    s1_grant = grant1; s1_busy = busy1;
  endtask

  task automatic cyc(input logic r, input logic [15:0] q,
                     input logic [47:0] d, input logic rdy);
    apply(r, q, d, rdy);
    @(negedge clk);
    snap();
    chk("model", dut_out(), m_exp());
    @(posedge clk);
    m_step();
    #1;
  endtask

  function automatic logic [47:0] rdin();
    return {16'($urandom), $urandom};
  endfunction

  typedef struct {
    logic        r;
    logic [15:0] q;
    logic [47:0] d;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t tab[10];

  initial begin
    logic [47:0] d5, dk;
    logic [24:0] b5, i5;
    int order[$];
    int hs;
    bit done;
    logic [2:0] d_ref;
    logic [15:0] q;

    d5 = 48'(5) << 15;
    b5 = {4'd5, 16'h0020, 1'b1, 1'b1, 3'd5};
    i5 = {4'd5, 16'h0000, 1'b0, 1'b0, 3'd0};
    tab[0] = '{1'b1, 16'h0020, d5, 1'b1, 25'h0};
    tab[1] = '{1'b0, 16'h0020, d5, 1'b1, 25'h0};
    tab[2] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[3] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[4] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[5] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[6] = '{1'b0, 16'h0020, d5, 1'b1, i5};
    tab[7] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[8] = '{1'b0, 16'h0020, d5, 1'b1, b5};
    tab[9] = '{1'b1, 16'h0020, d5, 1'b1, 25'h0};

    m_reset();
    @(posedge clk); #1;

    foreach (tab[i]) begin
      apply(tab[i].r, tab[i].q, tab[i].d, tab[i].rdy);
      @(negedge clk);
      chk($sformatf("tab%0d", i), dut_out(), tab[i].exp);
      @(posedge clk);
      m_step();
      #1;
    end

    // reset in the middle of a burst, then re-grant
    cyc(1, 16'h0008, rdin(), 1);
    cyc(0, 16'h0008, rdin(), 1);
    cyc(0, 16'h0008, rdin(), 1);
    cyc(0, 16'h0008, rdin(), 1);
    cyc(1, 16'h0008, rdin(), 1);
    chk("rst_mid", 25'({s_grant, s_busy, s_valid}), 25'h0);
    cyc(0, 16'h0008, rdin(), 1);
    chk("rst_idle", 25'(s_grant), 25'h0);
    cyc(0, 16'h0008, rdin(), 1);
    chk("rst_regrant", 25'(s_grant), 25'h0008);

    // rotation and wrap between 0 and 15
    cyc(1, 16'h8001, rdin(), 1);
    order.delete();
    for (int i = 0; i < 20; i++) begin
      logic pb;
      pb = s_busy;
      cyc(0, 16'h8001, rdin(), 1);
      if (s_busy && (!pb || i == 0)) order.push_back(int'(s_sel));
    end
    chk("rr_count", 25'(order.size()), 25'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("rr%0d", i), 25'(order[i]), (i % 2) ? 25'd15 : 25'd0);

    // early termination of requester 7
    cyc(1, 16'h0080, rdin(), 1);
    hs = 0;
    cyc(0, 16'h0080, rdin(), 1);
    cyc(0, 16'h0080, rdin(), 1);
    hs += int'(s_valid & s_ready);
    cyc(0, 16'h0080, rdin(), 1);
    hs += int'(s_valid & s_ready);
    cyc(0, 16'h0000, rdin(), 1);
    chk("early_drop", 25'({s_busy, s_valid}), 25'b10);
    cyc(0, 16'hFFFF, rdin(), 1);
    chk("early_idle", 25'(s_busy), 25'd0);
    chk("early_beats", 25'(hs), 25'd2);
    cyc(0, 16'hFFFF, rdin(), 1);
    chk("early_ptr", 25'({s_busy, s_sel}), 25'({1'b1, 4'd8}));

    // backpressure on requester 2
    dk = rdin();
    cyc(1, 16'h0004, dk, 1);
    hs = 0; done = 0; d_ref = '0;
    for (int i = 0; i < 12; i++) begin
      logic rdy;
      rdy = !(i >= 2 && i < 7);
      cyc(0, 16'h0004, dk, rdy);
      if (i == 1) d_ref = s_dout;
      if (i >= 2 && i < 7)
        chk("bp_stable", 25'({s_busy, s_sel, s_dout}),
            25'({1'b1, 4'd2, d_ref}));
      if (!done && s_busy && s_valid && s_ready) hs++;
      if (hs > 0 && !s_busy) done = 1;
    end
    chk("bp_beats", 25'(hs), 25'd4);

    // single-beat grants with everyone requesting
    cyc(1, 16'hFFFF, rdin(), 1);
    for (int i = 0; i < 34; i++) begin
      logic b;
      logic [15:0] g;
      cyc(0, 16'hFFFF, rdin(), 1);
      b = 1'(i % 2);
      g = b ? (16'd1 << ((i / 2) % 16)) : 16'd0;
      chk($sformatf("mb1_%0d", i), 25'({s1_busy, s1_grant}), 25'({b, g}));
    end

    // random traffic against the model
    q = '0;
    cyc(1, q, rdin(), 1);
    for (int i = 0; i < 3000; i++) begin
      q = q ^ 16'($urandom & $urandom & $urandom);
      cyc(($urandom % 100) == 0, q, rdin(), ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
